// File: rtl/machine_ctl_if.sv
// Control bundle between the instruction sequencer and the datapath it steers.
// The sequencer is the master: it consumes ena/opcode/zero and drives every strobe.
interface machine_ctl_if;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
   logic       inc_pc;
   logic       load_pc;
   logic       rd;
   logic       wr;
   logic       load_ir;
   logic       alu_ena;
   logic       load_acc;
   logic       datactl_ena;
   logic       halt;
   logic [3:0] state;

   modport master (
      input  ena, opcode, zero,
      output inc_pc, load_pc, rd, wr, load_ir, alu_ena, load_acc, datactl_ena, halt, state
   );

   modport slave (
      output ena, opcode, zero,
      input  inc_pc, load_pc, rd, wr, load_ir, alu_ena, load_acc, datactl_ena, halt, state
   );
endinterface

// File: rtl/machine_ctl.sv
// Eight-phase instruction sequencer for a simple accumulator machine.
// The state register steps on enabled edges; strobes are decoded from state, opcode and zero.
module machine_ctl (
   input  logic          clk,
   input  logic          rst,
   machine_ctl_if.master bus
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      S0     = 4'd1,
      S1     = 4'd2,
      S2     = 4'd3,
      S3     = 4'd4,
      S4     = 4'd5,
      S5     = 4'd6,
      S6     = 4'd7,
      S7     = 4'd8,
      HALTED = 4'd9
   } state_t;

   typedef enum logic [2:0] {
      OP_HLT  = 3'b000,
      OP_SKZ  = 3'b001,
      OP_ADD  = 3'b010,
      OP_ANDD = 3'b011,
      OP_XORR = 3'b100,
      OP_LDA  = 3'b101,
      OP_STO  = 3'b110,
      OP_JMP  = 3'b111
   } opcode_t;

   state_t  state_q;
   opcode_t op;
   logic    alu_class;

   logic inc_pc;
   logic load_pc;
   logic rd;
   logic wr;
   logic load_ir;
   logic alu_ena;
   logic load_acc;
   logic datactl_ena;
   logic halt;

   assign op        = opcode_t'(bus.opcode);
   assign alu_class = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);

   // HALTED only exits through reset; unused encodings fall back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else if (bus.ena) begin
         case (state_q)
            IDLE:    state_q <= S0;
            S0:      state_q <= S1;
            S1:      state_q <= S2;
            S2:      state_q <= S3;
            S3:      state_q <= (op == OP_HLT) ? HALTED : S4;
            S4:      state_q <= S5;
            S5:      state_q <= S6;
            S6:      state_q <= S7;
            S7:      state_q <= S0;
            HALTED:  state_q <= HALTED;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      load_ir     = 1'b0;
      alu_ena     = 1'b0;
      load_acc    = 1'b0;
      datactl_ena = 1'b0;
      halt        = 1'b0;
      case (state_q)
         S0: begin
            rd      = 1'b1;
            load_ir = 1'b1;
         end
         S1: begin
            rd      = 1'b1;
            load_ir = 1'b1;
            inc_pc  = 1'b1;
         end
         S3: begin
            inc_pc = 1'b1;
            halt   = (op == OP_HLT);
         end
         S4: begin
            if (alu_class) begin
               rd = 1'b1;
            end else if (op == OP_STO) begin
               datactl_ena = 1'b1;
            end else if (op == OP_JMP) begin
               load_pc = 1'b1;
            end
         end
         // The skip of SKZ is a second PC increment taken here and again in S7.
         S5: begin
            if (alu_class) begin
               rd      = 1'b1;
               alu_ena = 1'b1;
            end else if (op == OP_STO) begin
               datactl_ena = 1'b1;
               wr          = 1'b1;
            end else if (op == OP_JMP) begin
               load_pc = 1'b1;
               inc_pc  = 1'b1;
            end else if (op == OP_SKZ) begin
               inc_pc = bus.zero;
            end
         end
         S6: begin
            if (alu_class) begin
               rd       = 1'b1;
               load_acc = 1'b1;
            end else if (op == OP_STO) begin
               datactl_ena = 1'b1;
            end
         end
         S7: begin
            if (op == OP_SKZ) begin
               inc_pc = bus.zero;
            end
         end
         HALTED: begin
            halt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.inc_pc      = inc_pc;
   assign bus.load_pc     = load_pc;
   assign bus.rd          = rd;
   assign bus.wr          = wr;
   assign bus.load_ir     = load_ir;
   assign bus.alu_ena     = alu_ena;
   assign bus.load_acc    = load_acc;
   assign bus.datactl_ena = datactl_ena;
   assign bus.halt        = halt;
   assign bus.state       = state_q;

   // A write must never collide with a read and always has the accumulator on the bus.
   wr_protocol: assert property (@(posedge clk) disable iff (!rst)
      !(wr && (rd || !datactl_ena)));

endmodule

// File: tb/tb_machine_ctl.sv
// Scoreboard bench for machine_ctl: expected strobe vectors are queued as each cycle is
// driven and popped against the DUT at the falling edge.
module tb_machine_ctl;

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_S3     = 4'd4;
   localparam logic [3:0] ST_S5     = 4'd6;
   localparam logic [3:0] ST_S7     = 4'd8;
   localparam logic [3:0] ST_HALTED = 4'd9;

   localparam logic [9:0] B_S0   = 10'b00_0000_0010;
   localparam logic [9:0] B_S1   = 10'b00_0000_0100;
   localparam logic [9:0] B_S3   = 10'b00_0001_0000;
   localparam logic [9:0] B_S4   = 10'b00_0010_0000;
   localparam logic [9:0] B_S5   = 10'b00_0100_0000;
   localparam logic [9:0] B_S6   = 10'b00_1000_0000;
   localparam logic [9:0] B_S7   = 10'b01_0000_0000;
   localparam logic [9:0] B_HALT = 10'b10_0000_0000;

   // One bit per state code for each strobe: which states assert it for a given instruction.
   typedef struct packed {
      logic [9:0] inc_pc;
      logic [9:0] load_pc;
      logic [9:0] rd;
      logic [9:0] wr;
      logic [9:0] load_ir;
      logic [9:0] alu_ena;
      logic [9:0] load_acc;
      logic [9:0] dctl;
      logic [9:0] halt;
   } mask_t;

   logic clk;
   logic rst;
   machine_ctl_if bus();

   machine_ctl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors;
   int          miscompares;
   logic [3:0]  exp_state;
   mask_t       cur_mask;
   logic [12:0] exp_q[$];
   mask_t       m_alu, m_sto, m_skz1, m_skz0, m_jmp, m_hlt;

   function automatic logic [12:0] observe();
      return {bus.state, bus.inc_pc, bus.load_pc, bus.rd, bus.wr, bus.load_ir,
              bus.alu_ena, bus.load_acc, bus.datactl_ena, bus.halt};
   endfunction

   function automatic logic [12:0] expect_vec(input logic [3:0] st, input mask_t m);
      return {st, m.inc_pc[st], m.load_pc[st], m.rd[st], m.wr[st], m.load_ir[st],
              m.alu_ena[st], m.load_acc[st], m.dctl[st], m.halt[st]};
   endfunction

   function automatic logic [3:0] next_state(input logic [3:0] st, input logic [2:0] op);
      if (st == ST_HALTED) return ST_HALTED;
      if (st == ST_S3 && op == OP_HLT) return ST_HALTED;
      if (st == ST_S7 || st == ST_IDLE) return 4'd1;
      return st + 4'd1;
   endfunction

   function automatic mask_t fetch_mask();
      mask_t m;
      m         = '0;
      m.rd      = B_S0 | B_S1;
      m.load_ir = B_S0 | B_S1;
      m.inc_pc  = B_S1 | B_S3;
      return m;
   endfunction

   task automatic drive_cycle(input logic ena_v, input logic [2:0] op_v, input logic zero_v);
      bus.ena    = ena_v;
      bus.opcode = op_v;
      bus.zero   = zero_v;
      if (ena_v && rst) exp_state = next_state(exp_state, op_v);
      exp_q.push_back(expect_vec(exp_state, cur_mask));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.ena   = 1'b0;
      rst       = 1'b0;
      exp_state = ST_IDLE;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] got, expv;
      cur_mask  = m_alu;
      rst       = 1'b0;
      exp_state = ST_IDLE;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) rst = 1'b1;
         drive_cycle(i != 2 && i != 3, OP_LDA, 1'b0);
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL reset_seq[%0d]: got %h expected %h", i, got, expv);
         end
      end
      #2 rst = 1'b0;
      exp_state = ST_IDLE;
      exp_q.push_back(expect_vec(ST_IDLE, cur_mask));
      #1;
      got = observe(); expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("[TB] FAIL reset_async: got %h expected %h", got, expv);
      end
      drive_cycle(1'b1, OP_LDA, 1'b1);
      got = observe(); expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("[TB] FAIL reset_held: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_lda();
      logic [12:0] got, expv;
      logic [2:0]  op;
      do_reset();
      cur_mask = m_alu;
      for (int i = 0; i < 9; i++) begin
         op = (i < 2) ? 3'($urandom_range(0, 7)) : OP_LDA;
         drive_cycle(1'b1, op, 1'($urandom_range(0, 1)));
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL lda[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   task automatic test_sto();
      logic [12:0] got, expv;
      do_reset();
      cur_mask = m_sto;
      for (int i = 0; i < 9; i++) begin
         drive_cycle(1'b1, OP_STO, 1'($urandom_range(0, 1)));
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL sto[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   // zero is forced only where it is sampled and randomised everywhere else.
   task automatic test_skz();
      logic [12:0] got, expv;
      logic [3:0]  entering;
      logic        z;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cur_mask = (i < 8) ? m_skz1 : m_skz0;
         entering = 4'((i % 8) + 1);
         z = (entering == ST_S5 || entering == ST_S7) ? (i < 8) : 1'($urandom_range(0, 1));
         drive_cycle(1'b1, OP_SKZ, z);
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL skz[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   task automatic test_hlt();
      logic [12:0] got, expv;
      do_reset();
      cur_mask = m_hlt;
      for (int i = 0; i < 25; i++) begin
         if (i < 5) drive_cycle(1'b1, OP_HLT, 1'b0);
         else drive_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL hlt[%0d]: got %h expected %h", i, got, expv);
         end
      end
      #2 rst = 1'b0;
      exp_state = ST_IDLE;
      exp_q.push_back(expect_vec(ST_IDLE, cur_mask));
      #1;
      got = observe(); expv = exp_q.pop_front(); vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("[TB] FAIL hlt_reset: got %h expected %h", got, expv);
      end
   endtask

   task automatic test_jmp();
      logic [12:0] got, expv;
      logic        ena_pat[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1};
      do_reset();
      cur_mask = m_jmp;
      for (int i = 0; i < 11; i++) begin
         drive_cycle(ena_pat[i], OP_JMP, 1'($urandom_range(0, 1)));
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL jmp[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   task automatic test_abort();
      logic [12:0] got, expv;
      do_reset();
      cur_mask = m_alu;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) begin
            #2 rst = 1'b0;
            exp_state = ST_IDLE;
            exp_q.push_back(expect_vec(ST_IDLE, cur_mask));
            #1;
         end else begin
            if (i == 8) rst = 1'b1;
            drive_cycle(1'b1, OP_ADD, 1'b0);
         end
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL abort[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] got, expv;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cur_mask = (i < 8) ? m_alu : m_sto;
         drive_cycle(1'b1, (i < 8) ? OP_XORR : OP_STO, 1'($urandom_range(0, 1)));
         got = observe(); expv = exp_q.pop_front(); vectors++;
         if (got !== expv) begin
            miscompares++;
            $display("[TB] FAIL b2b[%0d]: got %h expected %h", i, got, expv);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.ena     = 1'b0;
      bus.opcode  = OP_HLT;
      bus.zero    = 1'b0;

      m_alu          = fetch_mask();
      m_alu.rd       = m_alu.rd | B_S4 | B_S5 | B_S6;
      m_alu.alu_ena  = B_S5;
      m_alu.load_acc = B_S6;

      m_sto      = fetch_mask();
      m_sto.dctl = B_S4 | B_S5 | B_S6;
      m_sto.wr   = B_S5;

      m_skz0        = fetch_mask();
      m_skz1        = fetch_mask();
      m_skz1.inc_pc = m_skz1.inc_pc | B_S5 | B_S7;

      m_jmp         = fetch_mask();
      m_jmp.load_pc = B_S4 | B_S5;
      m_jmp.inc_pc  = m_jmp.inc_pc | B_S5;

      m_hlt      = fetch_mask();
      m_hlt.halt = B_S3 | B_HALT;

      test_reset();
      test_lda();
      test_sto();
      test_skz();
      test_hlt();
      test_jmp();
      test_abort();
      test_back_to_back();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
